// File: rtl/ila_capture_sequencer.sv
// ila_capture_sequencer
//   Control block for the internal logic analyzer capture core. Arms the core,
//   sequences the trigger, waits for the core to stop writing, then drains the
//   capture memory oldest-first as a valid/ready stream.
//
// Ports
//   clk, reset              system clock, synchronous active-low reset
//   i_cmd_arm/force/abort   host command pulses
//   i_trig_en, i_trigger    external trigger gating and level
//   i_holdoff_cfg           holdoff value, latched on an accepted arm
//   o_core_restart          one-cycle restart pulse to the core
//   o_trigger, o_holdoff    trigger and holdoff to the core
//   i_primed, i_stopped     core status
//   i_waddr                 core write pointer (oldest sample once stopped)
//   o_raddr, i_rdata        core memory read port (1-cycle latency)
//   o_valid/i_ready/o_data/o_last   dump stream
//   o_busy, o_done          sequencer status
//
// state        | meaning
// -------------+---------------------------------------------------
// IDLE         | waiting for arm
// RESTART      | one-cycle restart pulse to the core
// WAIT_PRIMED  | waiting for the core to fill once; triggers dropped
// WAIT_TRIG    | waiting for external or forced trigger
// WAIT_STOP    | trigger held, waiting for the core to stop
// RD_ADDR      | read address presented, memory latency cycle
// RD_DATA      | read data captured into the stream register
// OUT          | word offered on the stream, waiting for ready
// DONE         | dump complete; arm starts a new capture
module ila_capture_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cmd_arm,
  input  logic                     i_cmd_force,
  input  logic                     i_cmd_abort,
  input  logic                     i_trig_en,
  input  logic                     i_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff_cfg,
  output logic                     o_core_restart,
  output logic                     o_trigger,
  output logic [HOLDOFF_WIDTH-1:0] o_holdoff,
  input  logic                     i_primed,
  input  logic                     i_stopped,
  input  logic [ADDR_WIDTH-1:0]    i_waddr,
  output logic [ADDR_WIDTH-1:0]    o_raddr,
  input  logic [DATA_WIDTH-1:0]    i_rdata,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RESTART, S_WAIT_PRIMED, S_WAIT_TRIG, S_WAIT_STOP,
    S_RD_ADDR, S_RD_DATA, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]    count, count_nxt;
  logic [ADDR_WIDTH-1:0]    raddr_nxt;
  logic [HOLDOFF_WIDTH-1:0] holdoff_nxt;
  logic [DATA_WIDTH-1:0]    data_nxt;
  logic                     trigger_nxt, valid_nxt, last_nxt;

  logic trig_event, handshake, idle_or_done;

  assign trig_event   = (i_trigger & i_trig_en) | i_cmd_force;
  assign handshake    = o_valid & i_ready;
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort takes priority over everything, including arm
  always_comb begin
    state_nxt = state;
    if (i_cmd_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (i_cmd_arm)  state_nxt = S_RESTART;
        S_RESTART:                      state_nxt = S_WAIT_PRIMED;
        S_WAIT_PRIMED:  if (i_primed)   state_nxt = S_WAIT_TRIG;
        S_WAIT_TRIG:    if (trig_event) state_nxt = S_WAIT_STOP;
        S_WAIT_STOP:    if (i_stopped)  state_nxt = S_RD_ADDR;
        S_RD_ADDR:                      state_nxt = S_RD_DATA;
        S_RD_DATA:                      state_nxt = S_OUT;
        S_OUT: begin
          if (handshake) state_nxt = o_last ? S_DONE : S_RD_ADDR;
        end
        default:                        state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: status decodes plus next values of the registered outputs
  always_comb begin
    o_core_restart = (state == S_RESTART);
    o_busy         = !idle_or_done;
    o_done         = (state == S_DONE);

    trigger_nxt = o_trigger;
    holdoff_nxt = o_holdoff;
    raddr_nxt   = o_raddr;
    count_nxt   = count;
    data_nxt    = o_data;
    valid_nxt   = o_valid;
    last_nxt    = o_last;

    if (i_cmd_abort) begin
      trigger_nxt = 1'b0;
      valid_nxt   = 1'b0;
      last_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (i_cmd_arm) holdoff_nxt = i_holdoff_cfg;
        S_WAIT_TRIG:    if (trig_event) trigger_nxt = 1'b1;
        S_WAIT_STOP: begin
          // Once stopped, the write pointer addresses the oldest sample
          if (i_stopped) begin
            trigger_nxt = 1'b0;
            raddr_nxt   = i_waddr;
            count_nxt   = '0;
          end
        end
        S_RD_DATA: begin
          data_nxt  = i_rdata;
          valid_nxt = 1'b1;
          last_nxt  = (count == LAST_COUNT);
        end
        S_OUT: begin
          if (handshake) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            raddr_nxt = o_raddr + ADDR_ONE;
            count_nxt = count + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and word counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_trigger <= 1'b0;
      o_holdoff <= '0;
      o_raddr   <= '0;
      count     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
    end else begin
      o_trigger <= trigger_nxt;
      o_holdoff <= holdoff_nxt;
      o_raddr   <= raddr_nxt;
      count     <= count_nxt;
      o_data    <= data_nxt;
      o_valid   <= valid_nxt;
      o_last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_ila_capture_sequencer.sv
module tb_ila_capture_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int HW = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cmd_arm, i_cmd_force, i_cmd_abort, i_trig_en, i_trigger;
  logic [HW-1:0] i_holdoff_cfg;
  logic          o_core_restart, o_trigger;
  logic [HW-1:0] o_holdoff;
  logic          i_primed, i_stopped;
  logic [AW-1:0] i_waddr, o_raddr;
  logic [DW-1:0] i_rdata, o_data;
  logic          o_valid, i_ready, o_last, o_busy, o_done;

  always #5 clk = ~clk;

  ila_capture_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_arm(i_cmd_arm), .i_cmd_force(i_cmd_force), .i_cmd_abort(i_cmd_abort),
    .i_trig_en(i_trig_en), .i_trigger(i_trigger), .i_holdoff_cfg(i_holdoff_cfg),
    .o_core_restart(o_core_restart), .o_trigger(o_trigger), .o_holdoff(o_holdoff),
    .i_primed(i_primed), .i_stopped(i_stopped), .i_waddr(i_waddr),
    .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Capture memory with one-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) i_rdata <= mem[o_raddr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a dump is the whole memory, oldest (write pointer) first
  logic [DW-1:0] exp_q[$];
  logic [HW-1:0] exp_holdoff = '0;
  int            n_words = 0;
  logic [DW-1:0] first_word, last_word;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  bit            prev_restart = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  task automatic load_expected(input logic [AW-1:0] start);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(mem[(int'(start) + k) % DEPTH]);
    n_words = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("holdoff", o_holdoff, exp_holdoff);
      check("busy_done_excl", o_busy & o_done, 0);
      if (o_core_restart) check("restart_width", prev_restart, 0);
      if (prev_stall) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, stall_data);
        check("stall_last", o_last, stall_last);
      end
      if (o_valid && i_ready && reset && !i_cmd_abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%0h required=none", o_data);
        end else begin
          check("word_data", o_data, exp_q[0]);
          check("word_last", o_last, exp_q.size() == 1);
          if (n_words == 0) first_word = o_data;
          if (o_last) last_word = o_data;
          void'(exp_q.pop_front());
          n_words++;
        end
      end
      prev_stall   = o_valid && !i_ready && reset && !i_cmd_abort;
      stall_data   = o_data;
      stall_last   = o_last;
      prev_restart = o_core_restart;
    end else begin
      prev_stall   = 1'b0;
      prev_restart = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [HW-1:0] hold, input bit use_force,
                         input logic [AW-1:0] waddr, input bit rand_ready);
    int n;
    i_primed = 0; i_stopped = 0; i_ready = 0;
    i_trig_en = !use_force; i_trigger = !use_force;
    i_holdoff_cfg = hold; i_cmd_arm = 1;
    tick();
    i_cmd_arm = 0; exp_holdoff = hold;
    check("restart_pulse", o_core_restart, 1);
    check("busy_armed", o_busy, 1);
    check("done_cleared", o_done, 0);
    tick();
    check("restart_end", o_core_restart, 0);
    repeat (4) tick();
    check("trig_while_unprimed", o_trigger, 0);
    i_primed = 1;
    tick();
    check("trig_before_event", o_trigger, 0);
    if (use_force) begin
      i_cmd_force = 1; tick(); i_cmd_force = 0;
    end else begin
      tick();
    end
    check("trig_after_event", o_trigger, 1);
    repeat (3) tick();
    check("trig_held", o_trigger, 1);
    i_waddr = waddr; i_stopped = 1;
    load_expected(waddr);
    tick();
    i_trigger = 0;
    check("trig_cleared_on_stop", o_trigger, 0);
    check("raddr_oldest", o_raddr, waddr);
    tick();
    check("valid_in_rd_data", o_valid, 0);
    tick();
    check("valid_first", o_valid, 1);
    check("first_data", o_data, mem[waddr]);
    n = 0;
    while (!o_done && n < 500) begin
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    i_ready = 0;
    check("dump_done", o_done, 1);
    check("dump_words", n_words, DEPTH);
    check("dump_leftover", exp_q.size(), 0);
    check("busy_after_dump", o_busy, 0);
    i_stopped = 0; i_primed = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0; i_cmd_arm = 0; i_cmd_force = 0; i_cmd_abort = 0;
    i_trig_en = 0; i_trigger = 0; i_holdoff_cfg = '0;
    i_primed = 0; i_stopped = 0; i_waddr = '0; i_ready = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 17 + 3);
    tick(); tick();
    reset = 1;
    mon_en = 1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_raddr", o_raddr, 0);
    check("rst_trigger", o_trigger, 0);
    check("rst_restart", o_core_restart, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);

    // Single capture, external trigger, oldest sample at 5
    capture(10'd3, 1'b0, 4'd5, 1'b0);
    check("s1_first_lit", first_word, 8'h58);
    check("s1_last_lit", last_word, 8'h47);

    // Re-arm from DONE with new holdoff, forced trigger, random backpressure
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 29 + 100);
    capture(10'd7, 1'b1, 4'd11, 1'b1);
    check("s2_holdoff_lit", o_holdoff, 10'd7);
    check("s2_first_lit", first_word, 8'hA3);
    check("s2_last_lit", last_word, 8'h86);

    // Gating: force dropped while unprimed, external trigger masked
    i_trig_en = 0; i_trigger = 1; i_primed = 0; i_stopped = 0;
    i_holdoff_cfg = 10'd2; i_cmd_arm = 1;
    tick();
    i_cmd_arm = 0; exp_holdoff = 10'd2;
    tick();
    i_cmd_force = 1; tick(); i_cmd_force = 0;
    check("force_unprimed", o_trigger, 0);
    repeat (2) tick();
    i_primed = 1;
    tick();
    repeat (4) tick();
    check("trig_masked", o_trigger, 0);
    check("trig_masked_busy", o_busy, 1);
    i_cmd_force = 1; tick(); i_cmd_force = 0;
    check("force_trig", o_trigger, 1);
    i_waddr = 4'd9; i_stopped = 1;
    load_expected(4'd9);
    tick();
    i_trigger = 0;
    n = 0;
    while (!o_valid && n < 10) begin tick(); n++; end
    check("abort_setup_valid", o_valid, 1);
    tick();
    i_cmd_abort = 1; tick(); i_cmd_abort = 0;
    exp_q.delete();
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_last", o_last, 0);
    i_stopped = 0; i_primed = 0;

    // Arm and abort together from WAIT_TRIG
    i_holdoff_cfg = 10'd9; i_cmd_arm = 1;
    tick();
    i_cmd_arm = 0; exp_holdoff = 10'd9;
    tick();
    i_primed = 1;
    tick();
    check("wait_trig_busy", o_busy, 1);
    i_holdoff_cfg = 10'd1; i_cmd_arm = 1; i_cmd_abort = 1;
    tick();
    i_cmd_arm = 0; i_cmd_abort = 0;
    check("arm_abort_busy", o_busy, 0);
    check("arm_abort_restart", o_core_restart, 0);
    tick();
    check("arm_abort_stays_idle", o_busy, 0);
    i_primed = 0;

    // Reset during WAIT_STOP
    i_trig_en = 1; i_trigger = 1; i_holdoff_cfg = 10'd5; i_cmd_arm = 1;
    tick();
    i_cmd_arm = 0; exp_holdoff = 10'd5;
    tick();
    i_primed = 1;
    tick(); tick();
    check("pre_reset_trigger", o_trigger, 1);
    check("pre_reset_raddr", o_raddr, 4'd9);
    reset = 0;
    tick();
    exp_holdoff = '0;
    check("midrst_trigger", o_trigger, 0);
    check("midrst_holdoff", o_holdoff, 0);
    check("midrst_raddr", o_raddr, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    reset = 1; i_trigger = 0; i_primed = 0;
    tick();
    check("post_reset_idle", o_busy, 0);
    check("post_reset_done", o_done, 0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
